// File: rtl/keyboard_pkg.sv
// Shared keyboard definitions: FSM states, note/key widths and mapping helpers.
package keyboard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned NUM_NOTES = 7;
  localparam int unsigned NOTE_W    = 4;
  localparam int unsigned KEY_W     = 7;
  localparam logic [NOTE_W-1:0] REST = '0;

  // Key pattern for a note; rests and out-of-range codes map to all-dark.
  function automatic logic [KEY_W-1:0] key_slice(
    input logic [NUM_NOTES*KEY_W-1:0] mapping,
    input logic [NOTE_W-1:0]          note
  );
    logic [KEY_W-1:0] pat;
    pat = '0;
    for (int k = 0; k < NUM_NOTES; k++) begin
      if (note == NOTE_W'(k + 1)) pat = mapping[KEY_W*k +: KEY_W];
    end
    return pat;
  endfunction

  // Codes 1..7 are notes; everything else plays as a rest.
  function automatic logic [NOTE_W-1:0] effective_note(input logic [NOTE_W-1:0] note);
    return (note != REST && note <= NOTE_W'(NUM_NOTES)) ? note : REST;
  endfunction

endpackage

// File: rtl/note_to_key_driver_if.sv
// Note command handshake between a song sequencer (master) and the key driver (slave).
interface note_to_key_driver_if #(
  parameter int unsigned DUR_W = 12
);
  logic [keyboard_pkg::NOTE_W-1:0] note_in;
  logic [DUR_W-1:0]                dur_in;
  logic                            note_valid;
  logic                            note_ready;

  modport master (
    output note_in,
    output dur_in,
    output note_valid,
    input  note_ready
  );

  modport slave (
    input  note_in,
    input  dur_in,
    input  note_valid,
    output note_ready
  );
endinterface

// File: rtl/tick_prescaler.sv
// Divides the system clock into a one-cycle tick every DIV cycles; clear restarts the phase.
module tick_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntW'(DIV - 1));

  // Free-running divider, wrapping on tick and restarting on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/note_to_key_driver.sv
// Plays timed note commands on the key LEDs: hold the note's key pattern for its
// duration, then a fixed silent gap, then report done and accept the next note.
module note_to_key_driver
  import keyboard_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned DUR_W     = 12,
  parameter int unsigned GAP_TICKS = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  note_to_key_driver_if.slave        cmd,
  input  logic [NUM_NOTES*KEY_W-1:0] key_mapping,
  output logic [KEY_W-1:0]           led_out,
  output logic [NOTE_W-1:0]          note_playing,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned GapW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  // Wide enough for both the longest note and the gap, so no compare can wrap.
  localparam int unsigned TcW  = (DUR_W > GapW) ? DUR_W : GapW;

  state_e            state_q, state_d;
  logic [TcW-1:0]    tcnt_q, tcnt_d;
  logic [TcW-1:0]    tcnt_inc;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [KEY_W-1:0]  pat_q, pat_d;
  logic              done_q, done_d;
  logic              run_q;
  logic              accept, abort, tick, play_end, gap_end, presc_clear;

  // run_q keeps note_ready low until the first clock after reset release.
  assign cmd.note_ready = run_q & enable & (state_q == IDLE);
  assign accept         = cmd.note_valid & cmd.note_ready;
  assign abort          = !enable && (state_q != IDLE);
  assign tcnt_inc       = tcnt_q + 1'b1;
  assign play_end       = (state_q == PLAY) && tick && (tcnt_inc == TcW'(dur_q));
  assign gap_end        = (state_q == GAP) &&
                          ((GAP_TICKS == 0) || (tick && (tcnt_inc == TcW'(GAP_TICKS))));
  assign presc_clear    = (state_q == IDLE) || abort || play_end;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (presc_clear),
    .tick  (tick)
  );

  // Next-state: accept in IDLE, count ticks in PLAY/GAP, abort when enable drops.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    dur_d   = dur_q;
    note_d  = note_q;
    pat_d   = pat_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PLAY;
          tcnt_d  = '0;
          note_d  = effective_note(cmd.note_in);
          dur_d   = (cmd.dur_in == '0) ? DUR_W'(1) : cmd.dur_in;
          pat_d   = key_slice(key_mapping, note_d);
        end
      end
      PLAY: begin
        if (play_end) begin
          state_d = GAP;
          tcnt_d  = '0;
        end else if (tick) begin
          tcnt_d = tcnt_inc;
        end
      end
      GAP: begin
        if (gap_end) begin
          state_d = IDLE;
          tcnt_d  = '0;
          done_d  = 1'b1;
        end else if (tick) begin
          tcnt_d = tcnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
    endcase
    // Abort wins over any tick-driven transition and suppresses done.
    if (abort) begin
      state_d = IDLE;
      tcnt_d  = '0;
      done_d  = 1'b0;
    end
  end

  // State, counters and latched command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      dur_q   <= '0;
      note_q  <= REST;
      pat_q   <= '0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      dur_q   <= dur_d;
      note_q  <= note_d;
      pat_q   <= pat_d;
      done_q  <= done_d;
      run_q   <= 1'b1;
    end
  end

  // Outputs decode from state so an asynchronous reset darkens the LEDs at once.
  always_comb begin
    led_out      = (state_q == PLAY) ? pat_q : '0;
    note_playing = (state_q == PLAY) ? note_q : REST;
    busy         = (state_q != IDLE);
    done         = done_q;
  end

endmodule

// File: tb/tb_note_to_key_driver.sv
// Bench for note_to_key_driver: directed scenarios plus random commands, with every
// output compared each cycle against a schedule-based reference model.
module tb_note_to_key_driver;
  import keyboard_pkg::*;

  localparam int unsigned CLK_HZ    = 1000;
  localparam int unsigned TICK_HZ   = 100;
  localparam int unsigned DIV       = CLK_HZ / TICK_HZ;
  localparam int unsigned DUR_W     = 4;
  localparam int unsigned GAP_TICKS = 2;
  localparam int          BOUND     = 500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [48:0] key_mapping = '0;
  logic [6:0]  led_out;
  logic [3:0]  note_playing;
  logic        busy, done;

  note_to_key_driver_if #(.DUR_W(DUR_W)) cmd ();

  note_to_key_driver #(
    .CLK_HZ    (CLK_HZ),
    .TICK_HZ   (TICK_HZ),
    .DUR_W     (DUR_W),
    .GAP_TICKS (GAP_TICKS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cmd          (cmd),
    .key_mapping  (key_mapping),
    .led_out      (led_out),
    .note_playing (note_playing),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: one note timeline anchored at its accept cycle.
  int         cyc = 0;
  int         m_acc = 0;
  int         m_dur = 1;
  logic [3:0] m_note = '0;
  logic [6:0] m_pat = '0;
  bit         m_active = 0;
  bit         m_live = 0;
  int         acc_cnt = 0;
  int         ph, k;
  logic [13:0] got_v, exp_v;
  logic        e_ready;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0;
      m_live   = 0;
    end
    // ph: 0 idle, 1 play, 2 gap, 3 done cycle
    ph = 0;
    if (m_active) begin
      k = cyc - m_acc;
      if (k >= 1 && k <= m_dur * DIV) ph = 1;
      else if (k > m_dur * DIV && k <= (m_dur + GAP_TICKS) * DIV) ph = 2;
      else if (k == (m_dur + GAP_TICKS) * DIV + 1) ph = 3;
    end
    e_ready = m_live && enable && (ph == 0 || ph == 3);
    exp_v = {(ph == 1) ? m_pat : 7'd0, (ph == 1) ? m_note : 4'd0,
             (ph == 1 || ph == 2), (ph == 3), e_ready};
    got_v = {led_out, note_playing, busy, done, cmd.note_ready};
    check("outputs{led,note,busy,done,ready}", 32'(got_v), 32'(exp_v));
    if (e_ready && cmd.note_valid) begin
      m_acc    = cyc;
      m_note   = (cmd.note_in >= 1 && cmd.note_in <= 7) ? cmd.note_in : 4'd0;
      m_dur    = (cmd.dur_in == 0) ? 1 : int'(cmd.dur_in);
      m_pat    = (m_note == 0) ? 7'd0 : 7'((key_mapping >> (7 * (m_note - 1))) & 49'h7f);
      m_active = 1;
      acc_cnt++;
    end else if (!enable && (ph == 1 || ph == 2)) begin
      m_active = 0;
    end
    if (rst_n) m_live = 1;
    cyc++;
  end

  // Advance n clocks, leaving the bench 2 time units after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Present a command and hold it until the model sees it accepted.
  task automatic send(input logic [3:0] n, input logic [DUR_W-1:0] d);
    int start;
    int waited;
    start  = acc_cnt;
    waited = 0;
    cmd.note_in    = n;
    cmd.dur_in     = d;
    cmd.note_valid = 1'b1;
    while (acc_cnt == start && waited < BOUND) begin
      @(posedge clk);
      #2;
      waited++;
    end
    cmd.note_valid = 1'b0;
    check("accept_wait_bound", 32'(waited < BOUND), 32'd1);
  endtask

  logic [63:0] rnd;
  logic [6:0]  exp_pat;

  initial begin
    cmd.note_in    = '0;
    cmd.dur_in     = '0;
    cmd.note_valid = 1'b0;
    for (int i = 0; i < 7; i++) key_mapping[7*i +: 7] = 7'(1 << i);
    enable = 1'b1;
    cycles(3);
    check("reset_led", 32'(led_out), 32'd0);
    check("reset_note", 32'(note_playing), 32'd0);
    check("reset_busy_done_ready", 32'({busy, done, cmd.note_ready}), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // Note 3 for 4 ticks.
    send(4'd3, 4'd4);
    check("note3_led", 32'(led_out), 32'b0000100);
    check("note3_playing", 32'(note_playing), 32'd3);

    // Rests: code 0 and out-of-range 12.
    send(4'd0, 4'd1);
    check("rest0_busy", 32'(busy), 32'd1);
    send(4'd12, 4'd1);
    check("rest12_led", 32'(led_out), 32'd0);

    // Zero duration counts as one tick.
    send(4'd7, 4'd0);
    check("note7_led", 32'(led_out), 32'b1000000);

    // Mapping change mid-note with the next command already waiting.
    send(4'd5, 4'd3);
    cycles(5);
    key_mapping = 49'h1_2345_6789_abcd;
    send(4'd2, 4'd2);
    exp_pat = 7'((key_mapping >> 7) & 49'h7f);
    check("remap_led", 32'(led_out), 32'(exp_pat));

    // Enable drops 15 cycles into PLAY.
    key_mapping = '0;
    for (int i = 0; i < 7; i++) key_mapping[7*i +: 7] = 7'(1 << i);
    send(4'd4, 4'd6);
    cycles(14);
    enable = 1'b0;
    cycles(1);
    check("abort_led", 32'(led_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    cmd.note_in    = 4'd1;
    cmd.dur_in     = 4'd1;
    cmd.note_valid = 1'b1;
    cycles(5);
    check("disabled_ready", 32'(cmd.note_ready), 32'd0);
    cmd.note_valid = 1'b0;
    enable = 1'b1;
    cycles(1);

    // Asynchronous reset mid-note, between clock edges.
    send(4'd6, 4'd8);
    cycles(10);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led_out), 32'd0);
    check("async_rst_busy_note", 32'({busy, note_playing}), 32'd0);
    @(posedge clk);
    #2;
    cycles(1);
    rst_n = 1'b1;
    cycles(2);
    send(4'd1, 4'd2);
    check("post_rst_led", 32'(led_out), 32'b0000001);

    // Longest duration the field can hold.
    send(4'd7, 4'd15);

    // Random commands, mappings and enable drops.
    for (int i = 0; i < 40; i++) begin
      rnd = {$urandom, $urandom};
      key_mapping = rnd[48:0];
      send(4'($urandom_range(0, 15)), DUR_W'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) begin
        cycles($urandom_range(0, 60));
        enable = 1'b0;
        cycles($urandom_range(1, 3));
        enable = 1'b1;
      end else begin
        cycles($urandom_range(0, 3));
      end
    end

    cycles(200);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
